// File: rtl/sort_mon_pkg.sv
// sort_mon_pkg: shared state encoding and sizes for the sort result monitor
package sort_mon_pkg;
    typedef enum logic [2:0] {IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT} state_t;
    localparam int NUM_ELEM = 8;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 32;
endpackage

// File: rtl/sort_result_monitor_sort_pair_cmp.sv
// sort_pair_cmp: a <= b, signed when SORT_MON_SIGNED_EN is defined, unsigned otherwise
module sort_pair_cmp #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         le
);
`ifdef SORT_MON_SIGNED_EN
    assign le = $signed(a) <= $signed(b);
`else
    assign le = a <= b;
`endif
endmodule

// File: rtl/sort_result_monitor.sv
// sort_result_monitor: detects core halt via frozen PC, snapshots the array and checks it is ascending (SORT_MON_SIGNED_EN selects signed compare)
module sort_result_monitor
    import sort_mon_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_CYCLES    = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_out,
    input  logic [DATA_W-1:0] element1,
    input  logic [DATA_W-1:0] element2,
    input  logic [DATA_W-1:0] element3,
    input  logic [DATA_W-1:0] element4,
    input  logic [DATA_W-1:0] element5,
    input  logic [DATA_W-1:0] element6,
    input  logic [DATA_W-1:0] element7,
    input  logic [DATA_W-1:0] element8,
    output logic              done,
    output logic              sorted_ok,
    output logic              timeout,
    output logic [IDX_W-1:0]  first_bad_idx,
    output logic [CNT_W-1:0]  cycle_count
);
    state_t            state;
    logic [DATA_W-1:0] prev_pc;
    logic [DATA_W-1:0] snap [NUM_ELEM];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  stable_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              halt;
    logic              tout;
    logic              pair_le;

    // next-value terms shared by the RUN and CHECK transitions
    always_comb begin
        stable_nxt = (pc_out == prev_pc) ? stable_cnt + CNT_W'(1) : '0;
        cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        halt       = stable_nxt == CNT_W'(STABLE_CYCLES - 1);
        tout       = (cycle_count + CNT_W'(1)) == CNT_W'(MAX_CYCLES);
        idx_nxt    = idx + IDX_W'(1);
    end

    sort_pair_cmp #(.W(DATA_W)) u_cmp (
        .a  (snap[idx]),
        .b  (snap[idx_nxt]),
        .le (pair_le)
    );

    // monitor FSM: halt detection, snapshot, one pair check per cycle, sticky verdict
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            sorted_ok     <= 1'b0;
            timeout       <= 1'b0;
            first_bad_idx <= '0;
            cycle_count   <= '0;
            stable_cnt    <= '0;
            idx           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    prev_pc     <= pc_out;
                    cycle_count <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    cycle_count <= cnt_inc;
                    prev_pc     <= pc_out;
                    stable_cnt  <= stable_nxt;
                    if (halt) begin
                        snap  <= '{element1, element2, element3, element4,
                                   element5, element6, element7, element8};
                        idx   <= '0;
                        state <= CHECK;
                    end else if (tout) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= TIMEOUT;
                    end
                end
                CHECK: begin
                    if (!pair_le) begin
                        first_bad_idx <= idx;
                        done          <= 1'b1;
                        state         <= FAIL;
                    end else if (idx == IDX_W'(NUM_ELEM - 2)) begin
                        sorted_ok <= 1'b1;
                        done      <= 1'b1;
                        state     <= PASS;
                    end else begin
                        idx <= idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_result_monitor.sv
// tb_sort_result_monitor: randomized and directed checks of sort_result_monitor against a window-based reference model
module tb_sort_result_monitor;
    localparam int S    = 8;
    localparam int MAXC = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_out = '0;
    logic [63:0] element1 = '0, element2 = '0, element3 = '0, element4 = '0;
    logic [63:0] element5 = '0, element6 = '0, element7 = '0, element8 = '0;
    logic        done, sorted_ok, timeout;
    logic [2:0]  first_bad_idx;
    logic [31:0] cycle_count;

    logic [63:0] pcq [$];
    logic [63:0] ev [8];
    int vectors = 0;
    int miscompares = 0;

    sort_result_monitor #(.DATA_W(64), .STABLE_CYCLES(S), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .pc_out(pc_out),
        .element1(element1), .element2(element2), .element3(element3), .element4(element4),
        .element5(element5), .element6(element6), .element7(element7), .element8(element8),
        .done(done), .sorted_ok(sorted_ok), .timeout(timeout),
        .first_bad_idx(first_bad_idx), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pc_at(input int k);
        return (k < pcq.size()) ? pcq[k] : pcq[pcq.size() - 1];
    endfunction

    function automatic bit le64(input logic [63:0] a, input logic [63:0] b);
`ifdef SORT_MON_SIGNED_EN
        return $signed(a) <= $signed(b);
`else
        return a <= b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_elems(input logic [63:0] v [8]);
        {element1, element2, element3, element4} = {v[0], v[1], v[2], v[3]};
        {element5, element6, element7, element8} = {v[4], v[5], v[6], v[7]};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".sorted_ok"}, sorted_ok, 0);
        chk({tag, ".timeout"}, timeout, 0);
        chk({tag, ".first_bad_idx"}, first_bad_idx, 0);
        chk({tag, ".cycle_count"}, cycle_count, 0);
    endtask

    // expected halt = first RUN cycle n whose last S pc samples (incl. IDLE sample 0) are all equal
    task automatic scenario(input string tag, input bit abort, input bit change_after);
        int n_end = MAXC;
        bit halted = 0;
        int bad = -1;
        int done_k;
        int last_k;
        logic [63:0] cur [8];
        for (int n = S - 1; n <= MAXC && !halted; n++) begin
            bit eq = 1;
            for (int j = n - S + 2; j <= n; j++)
                if (pc_at(j) !== pc_at(n - S + 1)) eq = 0;
            if (eq) begin
                halted = 1;
                n_end = n;
            end
        end
        if (halted)
            for (int i = 0; i < 7; i++)
                if (bad < 0 && !le64(ev[i], ev[i + 1])) bad = i;
        done_k = !halted ? MAXC : (bad >= 0 ? n_end + bad + 1 : n_end + 7);
        last_k = abort ? n_end + 3 : done_k + 3;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_zero({tag, ".rst"});
        reset = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            pc_out = pc_at(k);
            for (int i = 0; i < 8; i++)
                cur[i] = (change_after && k > n_end) ? {$urandom, $urandom} : ev[i];
            drive_elems(cur);
            @(posedge clk); #1;
            chk({tag, ".done"}, done, 64'(k >= done_k));
            chk({tag, ".cycle_count"}, cycle_count, 64'(k < n_end ? k : n_end));
            chk({tag, ".sorted_ok"}, sorted_ok, 64'(k >= done_k && halted && bad < 0));
            chk({tag, ".timeout"}, timeout, 64'(k >= done_k && !halted));
            chk({tag, ".first_bad_idx"}, first_bad_idx, (k >= done_k && bad >= 0) ? 64'(bad) : 64'd0);
        end
        if (abort) begin
            reset = 1'b0;
            @(posedge clk); #1;
            chk_zero({tag, ".abort"});
            reset = 1'b1;
        end
    endtask

    task automatic pc_ramp_hold(input int m);
        pcq.delete();
        for (int k = 0; k <= m; k++) pcq.push_back(64'(4 * k));
    endtask

    initial begin
        logic [63:0] v;
        // 1: ramp 50 cycles then hold, sorted
        pc_ramp_hold(50);
        ev = '{1, 2, 3, 4, 5, 6, 7, 8};
        scenario("t1_sorted", 0, 0);
        // 2: violation at index 2
        ev = '{1, 2, 9, 4, 5, 6, 7, 8};
        scenario("t2_bad2", 0, 0);
        // 3: pc never stalls
        pc_ramp_hold(400);
        scenario("t3_timeout", 0, 0);
        // 4: all equal, elements disturbed after halt
        pc_ramp_hold(20);
        ev = '{5, 5, 5, 5, 5, 5, 5, 5};
        scenario("t4_equal", 0, 1);
        // 5: all-ones first element, signedness decides verdict
        pc_ramp_hold(30);
        ev = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 3, 4, 5, 6, 7};
        scenario("t5_sign", 0, 0);
        // 6: reset mid-check, then a clean rerun
        pc_ramp_hold(50);
        ev = '{1, 2, 3, 4, 5, 6, 7, 8};
        scenario("t6_abort", 1, 0);
        scenario("t6_rerun", 0, 0);
        // 7: stall one sample short of halt, then move on
        pcq.delete();
        pcq = '{0, 4};
        for (int k = 0; k < S - 1; k++) pcq.push_back(8);
        for (int k = 3; k < 10; k++) pcq.push_back(64'(4 * k));
        scenario("t7_short_stall", 0, 0);
        // random runs: random pcs with sub-threshold stalls, random or near-sorted arrays
        for (int r = 0; r < 8; r++) begin
            int m = $urandom_range(5, 60);
            pcq.delete();
            pcq.push_back({$urandom, $urandom});
            while (pcq.size() < m) begin
                if ($urandom_range(0, 2) == 0) begin
                    int rep = $urandom_range(1, S - 2);
                    for (int j = 0; j < rep; j++) pcq.push_back(pcq[pcq.size() - 1]);
                end
                v = {$urandom, $urandom};
                pcq.push_back(v);
            end
            if (r % 2 == 0) begin
                ev[0] = 64'($urandom_range(0, 100));
                for (int i = 1; i < 8; i++) ev[i] = ev[i - 1] + 64'($urandom_range(0, 3));
                if (r % 4 == 2) ev[$urandom_range(1, 7)] = 0;
            end else begin
                for (int i = 0; i < 8; i++) ev[i] = {$urandom, $urandom};
            end
            scenario("rand", 0, r[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
